// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
//
// Shared definitions for the single-clock threshold FIFO family:
//   - default geometry and threshold constants
//   - pointer width helper (ASIZE+1: address bits plus one wrap bit)
//   - elaboration-time range checks for the threshold parameters
//   - the packed status-flag bundle and its reset/flush value
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int DEF_DSIZE    = 8;
  localparam int DEF_ASIZE    = 3;
  localparam int DEF_AF_LEVEL = 6;
  localparam int DEF_AE_LEVEL = 1;

  // Pointer width: the low ASIZE bits address memory, the extra MSB is the
  // wrap bit that distinguishes full from empty when the low bits are equal.
  function automatic int ptr_width(input int asize);
    return asize + 1;
  endfunction

  function automatic bit geometry_ok(input int dsize, input int asize);
    return (dsize >= 1) && (asize >= 1);
  endfunction

  // Almost-full threshold must be reachable and non-trivial: 1..DEPTH.
  function automatic bit af_level_ok(input int af_level, input int asize);
    return (af_level >= 1) && (af_level <= (1 << asize));
  endfunction

  // Almost-empty threshold: 0..DEPTH-1.
  function automatic bit ae_level_ok(input int ae_level, input int asize);
    return (ae_level >= 0) && (ae_level <= (1 << asize) - 1);
  endfunction

  // Occupancy-derived status flags, registered together.
  typedef struct packed {
    logic wr_full;
    logic wr_almost_full;
    logic rd_empty;
    logic rd_almost_empty;
  } flags_t;

  // Value of the flags for an empty FIFO (after reset or flush).
  localparam flags_t FLAGS_EMPTY = '{
    wr_full:         1'b0,
    wr_almost_full:  1'b0,
    rd_empty:        1'b1,
    rd_almost_empty: 1'b1
  };

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
//
// DSIZE x 2^ASIZE storage array for sync_fifo_thresh. One synchronous write
// port and one combinational read port; the FIFO top registers the read data,
// so all control and output timing lives there.
//
// Ports:
//   clk      in   write clock
//   wr_en    in   write strobe (already qualified by the top)
//   wr_addr  in   ASIZE  write address
//   wr_data  in   DSIZE  write data
//   rd_addr  in   ASIZE  read address
//   rd_data  out  DSIZE  contents at rd_addr
// -----------------------------------------------------------------------------
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [ASIZE-1:0] wr_addr,
  input  logic [DSIZE-1:0] wr_data,
  input  logic [ASIZE-1:0] rd_addr,
  output logic [DSIZE-1:0] rd_data
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents are only meaningful once written,
  // and the pointers/flags in the top decide what is valid. Resetting it would
  // prevent RAM inference for no functional gain.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo_thresh.sv
// -----------------------------------------------------------------------------
// sync_fifo_thresh
//
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and a
// synchronous flush. All outputs are registered.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through: rd_data always
//                                   shows the head entry while rd_empty=0.
//                      undefined -> standard: rd_data loads at the edge that
//                                   accepts a read (1-cycle latency), holds
//                                   otherwise.
//
// Parameters: DSIZE data width, ASIZE address width (DEPTH = 2^ASIZE),
//             AF_LEVEL almost-full threshold (1..DEPTH),
//             AE_LEVEL almost-empty threshold (0..DEPTH-1).
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-low reset
//   clear            in   synchronous flush, overrides wr_inc/rd_inc
//   wr_data          in   DSIZE   write data
//   wr_inc           in   write request
//   wr_full          out  FIFO holds DEPTH entries
//   wr_almost_full   out  count >= AF_LEVEL
//   wr_overflow      out  sticky: write attempted while full
//   rd_inc           in   read request
//   rd_data          out  DSIZE   read data
//   rd_empty         out  FIFO holds 0 entries
//   rd_almost_empty  out  count <= AE_LEVEL
//   rd_underflow     out  sticky: read attempted while empty
//   count            out  ASIZE+1 occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_thresh
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE    = DEF_DSIZE,
  parameter int ASIZE    = DEF_ASIZE,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DSIZE-1:0] wr_data,
  input  logic             wr_inc,
  output logic             wr_full,
  output logic             wr_almost_full,
  output logic             wr_overflow,
  input  logic             rd_inc,
  output logic [DSIZE-1:0] rd_data,
  output logic             rd_empty,
  output logic             rd_almost_empty,
  output logic             rd_underflow,
  output logic [ASIZE:0]   count
);

  localparam int             PW     = ptr_width(ASIZE);
  localparam logic [PW-1:0]  AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0]  AE_CNT = PW'(AE_LEVEL);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (!geometry_ok(DSIZE, ASIZE)) begin : g_bad_geometry
    $error("sync_fifo_thresh: DSIZE and ASIZE must both be >= 1");
  end
  if (!af_level_ok(AF_LEVEL, ASIZE)) begin : g_bad_af_level
    $error("sync_fifo_thresh: AF_LEVEL must lie in 1..2**ASIZE");
  end
  if (!ae_level_ok(AE_LEVEL, ASIZE)) begin : g_bad_ae_level
    $error("sync_fifo_thresh: AE_LEVEL must lie in 0..2**ASIZE-1");
  end

  // ---------------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------------
  logic [PW-1:0]    wptr, rptr;
  logic [PW-1:0]    wptr_next, rptr_next, count_next;
  logic             wr_accept, rd_accept;
  flags_t           flags_next;
  logic [ASIZE-1:0] mem_rd_addr;
  logic [DSIZE-1:0] mem_rd_data;
  logic [DSIZE-1:0] rd_data_next;
  logic             rd_data_load;

  // Acceptance uses only the registered (pre-edge) flags. This gives the
  // required priority for free: at full a concurrent read is accepted and the
  // write rejected; at empty the write is accepted and the read rejected.
  assign wr_accept = wr_inc && !wr_full;
  assign rd_accept = rd_inc && !rd_empty;

  // NOTE: every variable driven here gets a default assignment first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wptr_next  = wptr + PW'(wr_accept);
    rptr_next  = rptr + PW'(rd_accept);
    count_next = count;
    if (wr_accept && !rd_accept) begin
      count_next = count + PW'(1);
    end else if (rd_accept && !wr_accept) begin
      count_next = count - PW'(1);
    end

    // Full/empty from the pointer pair; thresholds from the occupancy.
    flags_next.wr_full         = (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                                 (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
    flags_next.rd_empty        = (wptr_next == rptr_next);
    flags_next.wr_almost_full  = (count_next >= AF_CNT);
    flags_next.rd_almost_empty = (count_next <= AE_CNT);
  end

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
  // The output register tracks the head of the post-edge FIFO. The head slot
  // is rptr_next; if that slot is being written at this same edge (FIFO empty,
  // or a single entry being popped while a new one arrives) the memory does
  // not hold it yet, so bypass wr_data. When the FIFO goes empty the register
  // simply holds, since its value is not meaningful then.
  assign mem_rd_addr  = rptr_next[ASIZE-1:0];
  assign rd_data_load = !flags_next.rd_empty;

  always_comb begin
    rd_data_next = mem_rd_data;
    if (wr_accept && (rptr_next == wptr)) begin
      rd_data_next = wr_data;
    end
  end
`else
  // Standard mode: the entry at the current read pointer is captured at the
  // edge that accepts the read and held until the next accepted read.
  assign mem_rd_addr  = rptr[ASIZE-1:0];
  assign rd_data_load = rd_accept;
  assign rd_data_next = mem_rd_data;
`endif

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // A flush overrides a concurrent write, so the memory write is masked too.
  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_accept && !clear),
    .wr_addr (wptr[ASIZE-1:0]),
    .wr_data (wr_data),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
      rd_data      <= '0;
      {wr_full, wr_almost_full, rd_empty, rd_almost_empty} <= FLAGS_EMPTY;
    end else if (clear) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wr_overflow  <= 1'b0;
      rd_underflow <= 1'b0;
      rd_data      <= '0;
      {wr_full, wr_almost_full, rd_empty, rd_almost_empty} <= FLAGS_EMPTY;
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      count <= count_next;
      {wr_full, wr_almost_full, rd_empty, rd_almost_empty} <= flags_next;
      if (wr_inc && wr_full) begin
        wr_overflow <= 1'b1;
      end
      if (rd_inc && rd_empty) begin
        rd_underflow <= 1'b1;
      end
      if (rd_data_load) begin
        rd_data <= rd_data_next;
      end
    end
  end

endmodule : sync_fifo_thresh

// File: tb/tb_sync_fifo_thresh.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_thresh
//
// Scoreboard bench for sync_fifo_thresh (DSIZE=8, ASIZE=3, AF_LEVEL=6,
// AE_LEVEL=1). The driver issues directed per-cycle vectors and pushes the
// expected post-edge status (and, in standard mode, the expected read data)
// into queues; an independent monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_thresh;

  localparam int DSIZE    = 8;
  localparam int ASIZE    = 3;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 1;
  localparam int DEPTH    = 1 << ASIZE;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic [DSIZE-1:0] wr_data = '0;
  logic             wr_inc = 1'b0;
  logic             rd_inc = 1'b0;
  logic             wr_full, wr_almost_full, wr_overflow;
  logic [DSIZE-1:0] rd_data;
  logic             rd_empty, rd_almost_empty, rd_underflow;
  logic [ASIZE:0]   count;

  sync_fifo_thresh #(
    .DSIZE    (DSIZE),
    .ASIZE    (ASIZE),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .wr_data         (wr_data),
    .wr_inc          (wr_inc),
    .wr_full         (wr_full),
    .wr_almost_full  (wr_almost_full),
    .wr_overflow     (wr_overflow),
    .rd_inc          (rd_inc),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_underflow    (rd_underflow),
    .count           (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    bit         full;
    bit         afull;
    bit         empty;
    bit         aempty;
    bit         ovf;
    bit         udf;
    bit         head_valid;
    logic [7:0] head;
  } status_t;

  status_t    exp_status[$];
  logic [7:0] exp_data[$];
  logic [7:0] model_q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_fire;
  status_t    mon_s;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_rd_empty"}, 32'(rd_empty), 1);
    check({tag, "_rd_almost_empty"}, 32'(rd_almost_empty), 1);
    check({tag, "_wr_full"}, 32'(wr_full), 0);
    check({tag, "_wr_almost_full"}, 32'(wr_almost_full), 0);
    check({tag, "_wr_overflow"}, 32'(wr_overflow), 0);
    check({tag, "_rd_underflow"}, 32'(rd_underflow), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
  endtask

  // One clock of stimulus: drive at negedge, update the reference model with
  // pre-edge occupancy, queue the expected post-edge state, wait the edge.
  task automatic step(input bit wr, input logic [7:0] wd, input bit rd,
                      input bit clr = 1'b0);
    status_t s;
    bit      full, empty;
    @(negedge clk);
    wr_inc  = wr;
    wr_data = wd;
    rd_inc  = rd;
    clear   = clr;
    full    = (model_q.size() == DEPTH);
    empty   = (model_q.size() == 0);
    if (clr) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (wr && full)  m_ovf = 1'b1;
      if (rd && empty) m_udf = 1'b1;
      if (rd && !empty) begin
`ifdef SYNC_FIFO_FWFT_EN
        void'(model_q.pop_front());
`else
        exp_data.push_back(model_q.pop_front());
`endif
      end
      if (wr && !full) model_q.push_back(wd);
    end
    s.cnt        = model_q.size();
    s.full       = (s.cnt == DEPTH);
    s.afull      = (s.cnt >= AF_LEVEL);
    s.empty      = (s.cnt == 0);
    s.aempty     = (s.cnt <= AE_LEVEL);
    s.ovf        = m_ovf;
    s.udf        = m_udf;
    s.head_valid = (s.cnt != 0);
    s.head       = s.head_valid ? model_q[0] : 8'h00;
    exp_status.push_back(s);
    @(posedge clk);
    #2;
    wr_inc = 1'b0;
    rd_inc = 1'b0;
    clear  = 1'b0;
  endtask

  // Monitor: read handshake is sampled at the edge (pre-update values), the
  // outputs one time unit later.
  initial begin
    forever begin
      @(posedge clk);
      mon_fire = rd_inc && !rd_empty && !clear && rst;
      #1;
      if (exp_status.size() > 0) begin
        mon_s = exp_status.pop_front();
        check("count", 32'(count), 32'(mon_s.cnt));
        check("wr_full", 32'(wr_full), 32'(mon_s.full));
        check("wr_almost_full", 32'(wr_almost_full), 32'(mon_s.afull));
        check("rd_empty", 32'(rd_empty), 32'(mon_s.empty));
        check("rd_almost_empty", 32'(rd_almost_empty), 32'(mon_s.aempty));
        check("wr_overflow", 32'(wr_overflow), 32'(mon_s.ovf));
        check("rd_underflow", 32'(rd_underflow), 32'(mon_s.udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (mon_s.head_valid) check("rd_data_head", 32'(rd_data), 32'(mon_s.head));
`endif
      end
`ifndef SYNC_FIFO_FWFT_EN
      if (mon_fire) begin
        check("rd_pop_pending", 32'(exp_data.size() > 0), 1);
        if (exp_data.size() > 0) check("rd_data", 32'(rd_data), 32'(exp_data.pop_front()));
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill: afull after 6th write, full after 8th, 9th overflows
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b1, 8'h99, 1'b0);

    // Drain: data 0x10..0x17, 9th read underflows and holds rd_data
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("rd_data_hold_after_underflow", 32'(rd_data), 32'h17);
`endif

    // Flush the sticky flags
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap: 3 in flight, 20 simultaneous write/read pairs, then drain
    for (int i = 0; i < 3; i++)  step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h50 + i), 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b0, 8'h00, 1'b1);

    // Simultaneous access at full: read wins, write overflows
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    // Simultaneous access at empty: write wins, read underflows
    step(1'b1, 8'h77, 1'b1);

    // Clear with count=5 and both sticky flags set, overriding wr/rd
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hCC, 1'b1, 1'b1);
    check("rd_data_after_clear", 32'(rd_data), 0);
    step(1'b1, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_a5_visible", 32'(rd_data), 32'hA5);
`endif
    step(1'b0, 8'h00, 1'b1);

    // Reset mid-traffic: asynchronous, between edges
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b1);
    @(negedge clk);
    wr_inc = 1'b1;
    rd_inc = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset("async_reset");
    model_q.delete();
    exp_data.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    wr_inc = 1'b0;
    rd_inc = 1'b0;
    rst    = 1'b1;

    // Operation resumes after reset
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (2) @(negedge clk);

    check("scoreboard_drained", 32'(exp_data.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sync_fifo_thresh

// File: doc/sync_fifo_thresh.md
# sync_fifo_thresh

Parametrised single-clock FIFO, the next generation of our FIFO family. It is used wherever producer and consumer share a clock. Compared with the async FIFO it adds:
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- sticky overflow and underflow error flags;
- a synchronous flush.

It sits between same-domain datapath stages and behind the UVM FIFO environment as a second DUT.

## Interface
Parameters:
- DSIZE, 8, data width in bits (≥1)
- ASIZE, 3, address width; depth DEPTH = 2^ASIZE (ASIZE ≥ 1)
- AF_LEVEL, 6, almost-full threshold, legal range 1..DEPTH
- AE_LEVEL, 1, almost-empty threshold, legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (assert async, deassert synchronised externally)
- clear  in  1  synchronous flush, active-high
- wr_data  in  DSIZE  write data
- wr_inc  in  1  write request
- wr_full  out  1  FIFO holds DEPTH entries
- wr_almost_full  out  1  count ≥ AF_LEVEL
- wr_overflow  out  1  sticky: a write was attempted while full
- rd_inc  in  1  read request
- rd_data  out  DSIZE  read data
- rd_empty  out  1  FIFO holds 0 entries
- rd_almost_empty  out  1  count ≤ AE_LEVEL
- rd_underflow  out  1  sticky: a read was attempted while empty
- count  out  ASIZE+1  current occupancy, 0..DEPTH

## Operation
- Pointers wptr and rptr are ASIZE+1 bits. The low ASIZE bits address memory; the MSB is the wrap bit.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- Write accepted when wr_inc && !wr_full: mem[wptr] ← wr_data, wptr+1.
- Read accepted when rd_inc && !rd_empty: rptr+1.
- Full with concurrent rd_inc and wr_inc: the read is accepted and the write is rejected. Decisions use pre-edge flags only.
- Empty with concurrent rd_inc and wr_inc: the write is accepted and the read is rejected.
- Rejected write: memory and pointers unchanged; wr_overflow ← 1.
- Rejected read: pointers and rd_data unchanged; rd_underflow ← 1.
- count next value:
  - +1 on write-only accept;
  - −1 on read-only accept;
  - unchanged when both or neither are accepted.
  - count never exceeds DEPTH or goes below 0.
- clear overrides wr_inc and rd_inc in the same cycle. It resets the pointers, count, both sticky flags and rd_data to 0, and sets rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0. Memory contents are not cleared.
- Pointer wrap-around is natural modulo 2^(ASIZE+1); no special casing.

## Timing
- All outputs are registered and reflect the state after the clock edge.
- Reset values: rd_data=0, rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0, count=0, wr_overflow=0, rd_underflow=0.
- Standard mode: rd_data is loaded at the edge that accepts the read, so data is valid in the following cycle (1-cycle latency). rd_data holds its value otherwise.
- Flags update at the same edge as count. A write into an empty FIFO deasserts rd_empty on the next cycle.
- Reset mid-operation discards everything immediately, without waiting for a clock edge.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data always presents the head entry whenever rd_empty=0.
  - rd_inc pops the head, and the next entry appears the cycle after the pop.
  - Data written into an empty FIFO appears on rd_data the cycle after the write, together with rd_empty falling.
  - A 1-entry output register is kept in sync. count includes the entry held in that output register.
- Not defined: standard mode as described in Timing.

## Structure
- Package sync_fifo_pkg holds:
  - default DSIZE, ASIZE, AF_LEVEL and AE_LEVEL constants;
  - a ptr_t width helper (ASIZE+1);
  - elaboration-time parameter-range checks (AF_LEVEL and AE_LEVEL bounds).
- Sub-module sync_fifo_mem: DSIZE × 2^ASIZE storage array with one synchronous write port and one read port. All control logic stays in the top module.

## Test plan
All scenarios use DSIZE=8, ASIZE=3, AF_LEVEL=6, AE_LEVEL=1.
- Reset: rst=0 mid-traffic → all outputs at reset values immediately; count=0, rd_empty=1.
- Fill: 8 writes of 0x10..0x17 → wr_almost_full rises after the 6th write, wr_full after the 8th, count=8. A 9th write sets wr_overflow=1 and leaves count=8.
- Drain: 8 reads → rd_data returns 0x10..0x17 in order, with rd_almost_empty rising at count=1 and rd_empty at 0. A 9th read sets rd_underflow=1 and leaves rd_data=0x17.
- Wrap: 20 interleaved writes and reads with 3 entries in flight → data order preserved across the pointer wrap; count stays at 3.
- Simultaneous access at full: rd_inc and wr_inc together → read accepted, write rejected, count=7, wr_overflow=1. The same pair at empty → count=1, rd_underflow=1.
- Clear: assert clear with count=5 and both sticky flags set → next cycle count=0, flags 0, rd_empty=1. Under SYNC_FIFO_FWFT_EN, a write of 0xA5 then appears on rd_data one cycle later with no rd_inc.
